// File: rtl/comparator_pkg.sv
// Shared types for the multicycle comparator: FSM state encoding and the
// registered result pair.
package comparator_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  typedef struct packed {
    logic equals;
    logic less_than;
  } cmp_result_t;

  localparam cmp_result_t RESULT_CLEAR = '{equals: 1'b0, less_than: 1'b0};

endpackage

// File: rtl/comparator_chunk.sv
// Combinational compare of one W-bit chunk. In signed mode the chunk is
// treated as two's complement (used only for the most significant chunk).
module comparator_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         signed_mode,
  output logic         eq,
  output logic         lt
);

  logic signed [W-1:0] a_s;
  logic signed [W-1:0] b_s;

  // Equality ignores the mode; ordering reinterprets the sign bit in signed mode
  always_comb begin
    a_s = a;
    b_s = b;
    eq  = (a == b);
    lt  = signed_mode ? (a_s < b_s) : (a < b);
  end

endmodule

// File: rtl/comparator_multicycle.sv
// Sequential N-bit comparator: equality and less-than (signed or unsigned per
// transaction), CHUNK bits per cycle from the most significant chunk down.
// Optional build macro COMPARATOR_MULTICYCLE_EARLY_EXIT_EN: when defined the
// compare stops at the first differing chunk; otherwise latency is always
// NUM_CHUNKS cycles. Results are identical either way.
module comparator_multicycle
  import comparator_pkg::*;
#(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         is_signed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         equals,
  output logic         less_than
);

  localparam int NUM_CHUNKS = N / CHUNK;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  if ((CHUNK <= 0) || (N % CHUNK != 0)) begin : g_width_check
    $error("comparator_multicycle: N (%0d) must be a positive multiple of CHUNK (%0d)", N, CHUNK);
  end

  state_t             state;
  state_t             state_next;
  logic [N-1:0]       a_cap;
  logic [N-1:0]       b_cap;
  logic               signed_cap;
  logic [IDX_W-1:0]   idx;
  logic               decided;
  logic               lt_found;
  cmp_result_t        result;

  logic [CHUNK-1:0]   chunk_a;
  logic [CHUNK-1:0]   chunk_b;
  logic               chunk_signed;
  logic               chunk_eq;
  logic               chunk_lt;
  logic               last_chunk;
  logic               accept;
  logic               finish;
  logic               handoff;

  // Select the chunk under examination; only the top chunk carries the sign
  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      if (idx == IDX_W'(i)) begin
        chunk_a = a_cap[i*CHUNK +: CHUNK];
        chunk_b = b_cap[i*CHUNK +: CHUNK];
      end
    end
    chunk_signed = signed_cap && (idx == IDX_W'(NUM_CHUNKS - 1));
    last_chunk   = (idx == '0);
  end

  comparator_chunk #(
    .W (CHUNK)
  ) u_chunk (
    .a           (chunk_a),
    .b           (chunk_b),
    .signed_mode (chunk_signed),
    .eq          (chunk_eq),
    .lt          (chunk_lt)
  );

  // Handshake strobes and next-state decode
  always_comb begin
    in_ready   = rst && (state == S_IDLE);
    accept     = in_valid && in_ready;
    finish     = 1'b0;
    handoff    = (state == S_DONE) && out_ready;
    state_next = state;
    if (state == S_COMPARE) begin
`ifdef COMPARATOR_MULTICYCLE_EARLY_EXIT_EN
      finish = last_chunk || !chunk_eq;
`else
      finish = last_chunk;
`endif
    end
    case (state)
      S_IDLE:    if (accept)  state_next = S_COMPARE;
      S_COMPARE: if (finish)  state_next = S_DONE;
      S_DONE:    if (handoff) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand capture, chunk walk, first-difference latch and result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_cap      <= '0;
      b_cap      <= '0;
      signed_cap <= 1'b0;
      idx        <= '0;
      decided    <= 1'b0;
      lt_found   <= 1'b0;
      out_valid  <= 1'b0;
      result     <= RESULT_CLEAR;
    end else begin
      if (accept) begin
        a_cap      <= a;
        b_cap      <= b;
        signed_cap <= is_signed;
        idx        <= IDX_W'(NUM_CHUNKS - 1);
        decided    <= 1'b0;
        lt_found   <= 1'b0;
      end else if (state == S_COMPARE) begin
        // The most significant differing chunk decides; lower chunks never override
        if (!chunk_eq && !decided) begin
          decided  <= 1'b1;
          lt_found <= chunk_lt;
        end
        if (!last_chunk) begin
          idx <= idx - 1'b1;
        end
      end

      // The finishing cycle folds in the chunk being examined right now
      if (finish) begin
        out_valid        <= 1'b1;
        result.equals    <= !(decided || !chunk_eq);
        result.less_than <= decided ? lt_found : (!chunk_eq && chunk_lt);
      end else if (handoff) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign equals    = result.equals;
  assign less_than = result.less_than;

endmodule
